// File: rtl/wb_sevenseg.sv
`default_nettype none
// ============================================================================
// Module   : wb_sevenseg
// Purpose  : Wishbone slave for the Nexys4 8-digit multiplexed seven-segment
//            display. Software writes hex nibbles, per-digit enables, decimal
//            points and a blink mask; the block scans the anodes, decodes hex
//            to segments and blinks the masked digits on its own.
// Ports    : clk, reset        - clock, synchronous active-high reset
//            wb_*              - Wishbone slave (adr[3:2] decoded, sel lanes)
//            seg_n[6:0]        - segments a..g, active-low (bit0 = a)
//            dp_n              - decimal point, active-low
//            an_n[7:0]         - digit anodes, active-low, at most one low
// Revision : 1.0 - initial release
// ============================================================================
module wb_sevenseg #(
  parameter int SCAN_DIV     = 12500,
  parameter int BLANK_CYCLES = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] wb_adr_i,
  input  logic [31:0] wb_dat_i,
  output logic [31:0] wb_dat_o,
  input  logic [3:0]  wb_sel_i,
  input  logic        wb_stb_i,
  input  logic        wb_cyc_i,
  input  logic        wb_we_i,
  output logic        wb_ack_o,
  output logic [6:0]  seg_n,
  output logic        dp_n,
  output logic [7:0]  an_n
);

  localparam int P_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [P_W-1:0] c_p_last = P_W'(SCAN_DIV - 1);
  localparam logic [P_W-1:0] c_blank  = P_W'(BLANK_CYCLES);

  localparam logic [1:0] c_adr_data   = 2'd0;
  localparam logic [1:0] c_adr_ctrl   = 2'd1;
  localparam logic [1:0] c_adr_bdiv   = 2'd2;
  localparam logic [1:0] c_adr_status = 2'd3;

  // Only address bits [3:2] select a register.
  logic unused_adr;
  assign unused_adr = ^{wb_adr_i[31:4], wb_adr_i[1:0]};

  // Active-high gfedcba segment pattern for a hex nibble.
  function automatic logic [6:0] hex7(input logic [3:0] n);
    case (n)
      4'h0: hex7 = 7'h3F;  4'h1: hex7 = 7'h06;
      4'h2: hex7 = 7'h5B;  4'h3: hex7 = 7'h4F;
      4'h4: hex7 = 7'h66;  4'h5: hex7 = 7'h6D;
      4'h6: hex7 = 7'h7D;  4'h7: hex7 = 7'h07;
      4'h8: hex7 = 7'h7F;  4'h9: hex7 = 7'h6F;
      4'hA: hex7 = 7'h77;  4'hB: hex7 = 7'h7C;
      4'hC: hex7 = 7'h39;  4'hD: hex7 = 7'h5E;
      4'hE: hex7 = 7'h79;  default: hex7 = 7'h71;
    endcase
  endfunction

  logic [31:0]    data_q, data_d;
  logic [23:0]    ctrl_q, ctrl_d;      // [7:0] enable, [15:8] dp, [23:16] blink
  logic [31:0]    bdiv_q, bdiv_d;
  logic [31:0]    bcnt_q, bcnt_d;
  logic           phase_q, phase_d;
  logic [P_W-1:0] p_q, p_d;
  logic [2:0]     d_q, d_d;
  logic           ack_q, ack_d;
  logic [31:0]    dat_q, dat_d;
  logic [7:0]     an_n_q, an_n_d;
  logic [6:0]     seg_n_q, seg_n_d;
  logic           dp_n_q, dp_n_d;

  logic        req, wr, vis;
  logic [1:0]  reg_sel;
  logic [31:0] rd_data;

  always_comb begin
    data_d  = data_q;
    ctrl_d  = ctrl_q;
    bdiv_d  = bdiv_q;
    bcnt_d  = bcnt_q;
    phase_d = phase_q;
    p_d     = p_q;
    d_d     = d_q;

    // The ~ack term turns a held strobe into an ack every other cycle.
    req     = wb_stb_i & wb_cyc_i & ~ack_q;
    wr      = req & wb_we_i;
    reg_sel = wb_adr_i[3:2];
    ack_d   = req;

    case (reg_sel)
      c_adr_data: rd_data = data_q;
      c_adr_ctrl: rd_data = {8'h00, ctrl_q};
      c_adr_bdiv: rd_data = bdiv_q;
      default:    rd_data = {23'd0, phase_q, 5'd0, d_q};
    endcase
    dat_d = req ? rd_data : 32'd0;

    if (wr) begin
      for (int i = 0; i < 4; i++) begin
        if (wb_sel_i[i]) begin
          case (reg_sel)
            c_adr_data: data_d[8*i +: 8] = wb_dat_i[8*i +: 8];
            c_adr_ctrl: if (i < 3) ctrl_d[8*i +: 8] = wb_dat_i[8*i +: 8];
            c_adr_bdiv: bdiv_d[8*i +: 8] = wb_dat_i[8*i +: 8];
            default: ;
          endcase
        end
      end
    end

    // Digit scan: prescaler wrap advances the digit index.
    if (p_q == c_p_last) begin
      p_d = '0;
      d_d = d_q + 3'd1;
    end else begin
      p_d = p_q + P_W'(1);
    end

    // Blink: any BLINKDIV write restarts the period from phase 0.
    if (wr && reg_sel == c_adr_bdiv) begin
      bcnt_d  = 32'd0;
      phase_d = 1'b0;
    end else if (bdiv_q == 32'd0) begin
      bcnt_d  = 32'd0;
      phase_d = 1'b0;
    end else if (bcnt_q >= bdiv_q - 32'd1) begin
      bcnt_d  = 32'd0;
      phase_d = ~phase_q;
    end else begin
      bcnt_d  = bcnt_q + 32'd1;
    end

    // Display outputs from the live registers; the anode stays dark during
    // the blanking window at the start of each slot to avoid ghosting.
    vis     = ctrl_q[d_q] & ~(ctrl_q[16 + d_q] & phase_q);
    an_n_d  = (vis && p_q >= c_blank) ? ~(8'h01 << d_q) : 8'hFF;
    seg_n_d = ~hex7(data_q[{d_q, 2'b00} +: 4]);
    dp_n_d  = ~ctrl_q[8 + d_q];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      data_q  <= 32'd0;
      ctrl_q  <= 24'd0;
      bdiv_q  <= 32'd0;
      bcnt_q  <= 32'd0;
      phase_q <= 1'b0;
      p_q     <= '0;
      d_q     <= 3'd0;
      ack_q   <= 1'b0;
      dat_q   <= 32'd0;
      an_n_q  <= 8'hFF;
      seg_n_q <= 7'h7F;
      dp_n_q  <= 1'b1;
    end else begin
      data_q  <= data_d;
      ctrl_q  <= ctrl_d;
      bdiv_q  <= bdiv_d;
      bcnt_q  <= bcnt_d;
      phase_q <= phase_d;
      p_q     <= p_d;
      d_q     <= d_d;
      ack_q   <= ack_d;
      dat_q   <= dat_d;
      an_n_q  <= an_n_d;
      seg_n_q <= seg_n_d;
      dp_n_q  <= dp_n_d;
    end
  end

  assign wb_ack_o = ack_q;
  assign wb_dat_o = dat_q;
  assign an_n     = an_n_q;
  assign seg_n    = seg_n_q;
  assign dp_n     = dp_n_q;

endmodule
`default_nettype wire

// File: tb/tb_wb_sevenseg.sv
`default_nettype none
// ============================================================================
// Module   : tb_wb_sevenseg
// Purpose  : Directed self-checking bench for wb_sevenseg with a short scan
//            period (8 cycles per slot, 2 blank cycles).
// Revision : 1.0 - initial release
// ============================================================================
module tb_wb_sevenseg;

  localparam int SCAN_DIV = 8;
  localparam int BLANK    = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] wb_adr_i, wb_dat_i, wb_dat_o;
  logic [3:0]  wb_sel_i;
  logic        wb_stb_i, wb_cyc_i, wb_we_i, wb_ack_o;
  logic [6:0]  seg_n;
  logic        dp_n;
  logic [7:0]  an_n;

  wb_sevenseg #(.SCAN_DIV(SCAN_DIV), .BLANK_CYCLES(BLANK)) dut (
    .clk(clk), .reset(reset),
    .wb_adr_i(wb_adr_i), .wb_dat_i(wb_dat_i), .wb_dat_o(wb_dat_o),
    .wb_sel_i(wb_sel_i), .wb_stb_i(wb_stb_i), .wb_cyc_i(wb_cyc_i),
    .wb_we_i(wb_we_i), .wb_ack_o(wb_ack_o),
    .seg_n(seg_n), .dp_n(dp_n), .an_n(an_n)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Active-low patterns for digits 0..7 of DATA = 0x76543210.
  logic [6:0] seg_exp [8] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78};

  task automatic wb_write(input logic [31:0] adr, input logic [31:0] dat, input logic [3:0] sel);
    logic got;
    @(negedge clk);
    wb_adr_i = adr; wb_dat_i = dat; wb_sel_i = sel;
    wb_we_i = 1'b1; wb_stb_i = 1'b1; wb_cyc_i = 1'b1;
    got = 1'b0;
    for (int i = 0; i < 4 && !got; i++) begin
      @(negedge clk);
      if (wb_ack_o) got = 1'b1;
    end
    wb_stb_i = 1'b0; wb_cyc_i = 1'b0; wb_we_i = 1'b0;
    check_eq("wr_ack", {31'd0, got}, 32'd1);
  endtask

  task automatic wb_read(input logic [31:0] adr, output logic [31:0] dat);
    logic got;
    @(negedge clk);
    wb_adr_i = adr; wb_sel_i = 4'hF;
    wb_we_i = 1'b0; wb_stb_i = 1'b1; wb_cyc_i = 1'b1;
    got = 1'b0;
    dat = 32'hDEADBEEF;
    for (int i = 0; i < 4 && !got; i++) begin
      @(negedge clk);
      if (wb_ack_o) begin
        got = 1'b1;
        dat = wb_dat_o;
      end
    end
    wb_stb_i = 1'b0; wb_cyc_i = 1'b0;
    check_eq("rd_ack", {31'd0, got}, 32'd1);
  endtask

  // Scan observation statistics.
  int lit [8];
  int seg_err, onehot_err, dp_low, order_err, wraps, prev;

  task automatic scan_clear();
    for (int k = 0; k < 8; k++) lit[k] = 0;
    seg_err = 0; onehot_err = 0; dp_low = 0; order_err = 0; wraps = 0; prev = -1;
  endtask

  task automatic scan_run(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (dp_n == 1'b0) dp_low++;
      if (an_n != 8'hFF) begin
        int k;
        logic [7:0] m;
        k = -1;
        for (int j = 0; j < 8; j++) begin
          m = 8'h01 << j;
          if (an_n == ~m) k = j;
        end
        if (k < 0) onehot_err++;
        else begin
          lit[k]++;
          if (seg_n != seg_exp[k]) seg_err++;
          if (k != prev) begin
            if (prev >= 0 && k != (prev + 1) % 8) order_err++;
            if (prev == 7 && k == 0) wraps++;
            prev = k;
          end
        end
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, got running expected done");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] rd, d1, d2, d3;
    logic a1, a2, a3, found;
    int total;

    reset = 1'b1;
    wb_adr_i = 0; wb_dat_i = 0; wb_sel_i = 0;
    wb_stb_i = 0; wb_cyc_i = 0; wb_we_i = 0;
    repeat (3) @(negedge clk);
    check_eq("rst_an", {24'd0, an_n}, 32'hFF);
    check_eq("rst_seg", {25'd0, seg_n}, 32'h7F);
    check_eq("rst_dp", {31'd0, dp_n}, 32'd1);
    check_eq("rst_ack", {31'd0, wb_ack_o}, 32'd0);
    check_eq("rst_dat", wb_dat_o, 32'd0);
    reset = 1'b0;

    // All digits disabled: anodes dark, no decimal point.
    scan_clear(); scan_run(32);
    total = 0;
    for (int k = 0; k < 8; k++) total += lit[k];
    check_eq("idle_lit", total, 0);
    check_eq("idle_dp", dp_low, 0);
    wb_read(32'h0, rd); check_eq("rst_data", rd, 32'd0);
    wb_read(32'h4, rd); check_eq("rst_ctrl", rd, 32'd0);
    wb_read(32'h8, rd); check_eq("rst_bdiv", rd, 32'd0);

    // Full scan of all eight digits.
    wb_write(32'h0, 32'h76543210, 4'hF);
    wb_write(32'h4, 32'h000000FF, 4'hF);
    wb_read(32'h0, rd); check_eq("data_rb", rd, 32'h76543210);
    scan_clear(); scan_run(64);
    for (int k = 0; k < 8; k++) check_eq($sformatf("lit_all%0d", k), lit[k], 6);
    check_eq("seg_err", seg_err, 0);
    check_eq("onehot", onehot_err, 0);
    check_eq("dp_off", dp_low, 0);
    scan_run(16);
    check_eq("order", order_err, 0);
    check_eq("wrap", {31'd0, wraps > 0}, 32'd1);

    // Decimal point on digit 7 only: dp_n low for its whole 8-cycle slot.
    wb_write(32'h4, 32'h000080FF, 4'hF);
    scan_clear(); scan_run(64);
    check_eq("dp7", dp_low, 8);

    // Byte-lane write into CTRL.
    wb_write(32'h4, 32'h0, 4'hF);
    wb_write(32'h4, 32'hFFFF0F0F, 4'b0001);
    wb_read(32'h4, rd); check_eq("ctrl_lane", rd, 32'h0000000F);
    scan_clear(); scan_run(64);
    for (int k = 0; k < 8; k++) check_eq($sformatf("lit_lo%0d", k), lit[k], (k < 4) ? 6 : 0);
    check_eq("lane_dp", dp_low, 0);

    // Blink with a 40-cycle half-period.
    wb_write(32'h4, 32'h00FF00FF, 4'hF);
    wb_write(32'h8, 32'd40, 4'hF);
    repeat (15) @(negedge clk);
    wb_read(32'hC, rd); check_eq("phase0", {31'd0, rd[8]}, 32'd0);
    repeat (30) @(negedge clk);
    wb_read(32'hC, rd); check_eq("phase1", {31'd0, rd[8]}, 32'd1);
    scan_clear(); scan_run(20);
    total = 0;
    for (int k = 0; k < 8; k++) total += lit[k];
    check_eq("blink_dark", total + onehot_err, 0);
    repeat (10) @(negedge clk);
    wb_read(32'hC, rd); check_eq("phase0b", {31'd0, rd[8]}, 32'd0);
    wb_read(32'h8, rd); check_eq("bdiv_rb", rd, 32'd40);
    wb_write(32'h8, 32'd0, 4'hF);
    wb_read(32'hC, rd); check_eq("phase_clr", {31'd0, rd[8]}, 32'd0);
    repeat (50) @(negedge clk);
    wb_read(32'hC, rd); check_eq("phase_hold", {31'd0, rd[8]}, 32'd0);

    // Back-to-back STATUS reads with strobe held.
    @(negedge clk);
    wb_adr_i = 32'hC; wb_we_i = 1'b0; wb_stb_i = 1'b1; wb_cyc_i = 1'b1;
    @(negedge clk); a1 = wb_ack_o; d1 = wb_dat_o;
    @(negedge clk); a2 = wb_ack_o; d2 = wb_dat_o;
    @(negedge clk); a3 = wb_ack_o; d3 = wb_dat_o;
    wb_stb_i = 1'b0; wb_cyc_i = 1'b0;
    check_eq("b2b_ack1", {31'd0, a1}, 32'd1);
    check_eq("b2b_ack2", {31'd0, a2}, 32'd0);
    check_eq("b2b_ack3", {31'd0, a3}, 32'd1);
    check_eq("b2b_dat2", d2, 32'd0);
    check_eq("b2b_hi", d1 >> 3, 32'd0);
    check_eq("b2b_step", {31'd0, ((d3[2:0] - d1[2:0]) & 3'd7) <= 3'd1}, 32'd1);

    // Reset in the middle of a write while digit 2 is lit.
    found = 1'b0;
    for (int i = 0; i < 200 && !found; i++) begin
      @(negedge clk);
      if (an_n == 8'hFB) found = 1'b1;
    end
    check_eq("find_fb", {31'd0, found}, 32'd1);
    reset = 1'b1;
    wb_adr_i = 32'h0; wb_dat_i = 32'h12345678; wb_sel_i = 4'hF;
    wb_we_i = 1'b1; wb_stb_i = 1'b1; wb_cyc_i = 1'b1;
    @(negedge clk);
    check_eq("mid_ack", {31'd0, wb_ack_o}, 32'd0);
    check_eq("mid_an", {24'd0, an_n}, 32'hFF);
    check_eq("mid_seg", {25'd0, seg_n}, 32'h7F);
    reset = 1'b0;
    wb_stb_i = 1'b0; wb_cyc_i = 1'b0; wb_we_i = 1'b0;
    wb_read(32'h0, rd); check_eq("mid_data", rd, 32'd0);
    wb_read(32'h4, rd); check_eq("mid_ctrl", rd, 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
